// File: rtl/apu_triangle_path.sv
// NES-style APU triangle voice: 4-step frame sequencer, triangle channel
// ($4008/$400A/$400B) and a 4-bit to 8-bit output DAC.
module apu_triangle_path #(
    parameter int QUARTER_DIV = 7457
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       quarter_frame,
    output logic       half_frame,
    output logic [3:0] tri_out,
    output logic [7:0] dac_out
);

    localparam int DIV_W = (QUARTER_DIV > 1) ? $clog2(QUARTER_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(QUARTER_DIV - 1);

    function automatic logic [7:0] len_table(input logic [4:0] idx);
        logic [7:0] val;
        case (idx)
            5'd0:  val = 8'd10;   5'd1:  val = 8'd254;
            5'd2:  val = 8'd20;   5'd3:  val = 8'd2;
            5'd4:  val = 8'd40;   5'd5:  val = 8'd4;
            5'd6:  val = 8'd80;   5'd7:  val = 8'd6;
            5'd8:  val = 8'd160;  5'd9:  val = 8'd8;
            5'd10: val = 8'd60;   5'd11: val = 8'd10;
            5'd12: val = 8'd14;   5'd13: val = 8'd12;
            5'd14: val = 8'd26;   5'd15: val = 8'd14;
            5'd16: val = 8'd12;   5'd17: val = 8'd16;
            5'd18: val = 8'd24;   5'd19: val = 8'd18;
            5'd20: val = 8'd48;   5'd21: val = 8'd20;
            5'd22: val = 8'd96;   5'd23: val = 8'd22;
            5'd24: val = 8'd192;  5'd25: val = 8'd24;
            5'd26: val = 8'd72;   5'd27: val = 8'd26;
            5'd28: val = 8'd16;   5'd29: val = 8'd28;
            5'd30: val = 8'd32;   default: val = 8'd30;
        endcase
        return val;
    endfunction

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       step_q, step_d;
    logic             qf_q, qf_d, hf_q, hf_d;
    logic             ctrl_q, ctrl_d;
    logic [6:0]       rel_q, rel_d;
    logic [10:0]      period_q, period_d;
    logic [10:0]      timer_q, timer_d;
    logic [4:0]       idx_q, idx_d;
    logic [3:0]       tri_q, tri_d;
    logic [6:0]       lin_q, lin_d;
    logic [7:0]       len_q, len_d;
    logic             rflag_q, rflag_d;

    always_comb begin
        div_d    = div_q;
        step_d   = step_q;
        qf_d     = 1'b0;
        hf_d     = 1'b0;
        ctrl_d   = ctrl_q;
        rel_d    = rel_q;
        period_d = period_q;
        timer_d  = timer_q;
        idx_d    = idx_q;
        lin_d    = lin_q;
        len_d    = len_q;
        rflag_d  = rflag_q;

        // Half-frame fires on every second quarter tick (steps 1 and 3).
        if (div_q == DIV_LAST) begin
            div_d  = '0;
            qf_d   = 1'b1;
            hf_d   = step_q[0];
            step_d = step_q + 2'd1;
        end else begin
            div_d = div_q + 1'b1;
        end

        if (timer_q == 11'd0) begin
            timer_d = period_q;
            if (lin_q != 7'd0 && len_q != 8'd0)
                idx_d = idx_q + 5'd1;
        end else begin
            timer_d = timer_q - 11'd1;
        end

        if (qf_q) begin
            if (rflag_q)
                lin_d = rel_q;
            else if (lin_q != 7'd0)
                lin_d = lin_q - 7'd1;
            if (!ctrl_q)
                rflag_d = 1'b0;
        end

        if (hf_q && !ctrl_q && len_q != 8'd0)
            len_d = len_q - 8'd1;

        // Writes are applied last so a $400B load overrides tick updates.
        if (wr_en) begin
            case (wr_addr)
                2'd0: begin
                    ctrl_d = wr_data[7];
                    rel_d  = wr_data[6:0];
                end
                2'd2: period_d[7:0] = wr_data;
                2'd3: begin
                    period_d[10:8] = wr_data[2:0];
                    len_d          = len_table(wr_data[7:3]);
                    rflag_d        = 1'b1;
                end
                default: ;
            endcase
        end

        tri_d = idx_d[4] ? idx_d[3:0] : ~idx_d[3:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q    <= '0;
            step_q   <= 2'd0;
            qf_q     <= 1'b0;
            hf_q     <= 1'b0;
            ctrl_q   <= 1'b0;
            rel_q    <= 7'd0;
            period_q <= 11'd0;
            timer_q  <= 11'd0;
            idx_q    <= 5'd0;
            tri_q    <= 4'hF;
            lin_q    <= 7'd0;
            len_q    <= 8'd0;
            rflag_q  <= 1'b0;
        end else begin
            div_q    <= div_d;
            step_q   <= step_d;
            qf_q     <= qf_d;
            hf_q     <= hf_d;
            ctrl_q   <= ctrl_d;
            rel_q    <= rel_d;
            period_q <= period_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            tri_q    <= tri_d;
            lin_q    <= lin_d;
            len_q    <= len_d;
            rflag_q  <= rflag_d;
        end
    end

    assign quarter_frame = qf_q;
    assign half_frame    = hf_q;
    assign tri_out       = tri_q;
    assign dac_out       = {tri_q, tri_q};

endmodule

// File: tb/tb_apu_triangle_path.sv
// Scoreboard bench for apu_triangle_path: directed + random register traffic
// against a cycle-count based reference model of the triangle voice.
module tb_apu_triangle_path;

    localparam int Q = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = 2'd0;
    logic [7:0] wr_data = 8'd0;
    logic       quarter_frame, half_frame;
    logic [3:0] tri_out;
    logic [7:0] dac_out;

    apu_triangle_path #(.QUARTER_DIV(Q)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .quarter_frame(quarter_frame),
        .half_frame(half_frame), .tri_out(tri_out), .dac_out(dac_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       qf;
        logic       hf;
        logic [3:0] tri_v;
        logic [7:0] dac;
    } exp_t;

    exp_t sb_q[$];
    int total = 0, bad = 0, pushed = 0, popped = 0;

    int len_tab[32] = '{10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,
                        12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30};

    // Reference state: cycles since reset release, register contents,
    // counters and the tick values currently visible on the outputs.
    int m_cyc, m_ctrl, m_rel, m_per, m_tmr, m_idx, m_lin, m_len, m_rf, m_qf, m_hf;

    task automatic model_edge(input bit rst, input bit we, input int wa, input int wd);
        int n_lin, n_len, n_rf, n_tmr, n_idx;
        if (rst) begin
            m_cyc = 0; m_ctrl = 0; m_rel = 0; m_per = 0; m_tmr = 0; m_idx = 0;
            m_lin = 0; m_len = 0; m_rf = 0; m_qf = 0; m_hf = 0;
            return;
        end
        n_lin = m_lin; n_len = m_len; n_rf = m_rf;
        if (m_qf != 0) begin
            if (m_rf != 0) n_lin = m_rel;
            else if (m_lin > 0) n_lin = m_lin - 1;
            if (m_ctrl == 0) n_rf = 0;
        end
        if (m_hf != 0 && m_ctrl == 0 && m_len > 0) n_len = m_len - 1;
        if (m_tmr == 0) begin
            n_tmr = m_per;
            n_idx = (m_lin > 0 && m_len > 0) ? (m_idx + 1) % 32 : m_idx;
        end else begin
            n_tmr = m_tmr - 1;
            n_idx = m_idx;
        end
        m_cyc = m_cyc + 1;
        m_qf = (m_cyc % Q == 0) ? 1 : 0;
        m_hf = (m_cyc % (2 * Q) == 0) ? 1 : 0;
        if (we) begin
            case (wa)
                0: begin m_ctrl = (wd >> 7) & 1; m_rel = wd & 127; end
                2: m_per = (m_per & 'h700) | (wd & 255);
                3: begin
                    m_per = (m_per & 255) | ((wd & 7) << 8);
                    n_len = len_tab[(wd >> 3) & 31];
                    n_rf  = 1;
                end
                default: ;
            endcase
        end
        m_lin = n_lin; m_len = n_len; m_rf = n_rf; m_tmr = n_tmr; m_idx = n_idx;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        int t;
        t = (m_idx < 16) ? 15 - m_idx : m_idx - 16;
        e.qf    = (m_qf != 0);
        e.hf    = (m_hf != 0);
        e.tri_v = 4'(t);
        e.dac   = 8'(t * 17);
        return e;
    endfunction

    task automatic check(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, req);
        end
    endtask

    task automatic drive(input bit rst, input bit we, input int wa, input int wd);
        reset   = rst;
        wr_en   = we;
        wr_addr = wa[1:0];
        wr_data = wd[7:0];
        model_edge(rst, we, wa, wd);
        @(posedge clk);
        sb_q.push_back(model_out());
        pushed++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0);
    endtask

    task automatic wr(input int wa, input int wd);
        drive(1'b0, 1'b1, wa, wd);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            popped++;
            check("quarter_frame", int'(quarter_frame), int'(e.qf));
            check("half_frame", int'(half_frame), int'(e.hf));
            check("tri_out", int'(tri_out), int'(e.tri_v));
            check("dac_out", int'(dac_out), int'(e.dac));
        end
    end

    initial begin
        int r, wa, wd;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 0, 0);
        idle(20);

        // Halted length, long reload, period 10: full triangle sweep.
        wr(0, 'hE4); wr(2, 'h0A); wr(3, 'hB0);
        idle(400);
        wr(0, 'h64);
        idle(200);

        // Short linear count freezes the output mid-ramp.
        wr(0, 'h02); wr(3, 'hB0);
        idle(40);

        wr(3, 'h08);
        idle(20);
        wr(0, 'h7F); wr(3, 'h18);
        idle(60);

        // Reset in the middle of an active sequence.
        wr(0, 'hFF); wr(2, 'h01); wr(3, 'hF8);
        idle(30);
        drive(1'b1, 1'b0, 0, 0);
        idle(20);

        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 999));
            if (r < 2) begin
                drive(1'b1, 1'b0, 0, 0);
            end else if (r < 130) begin
                wa = int'($urandom_range(0, 3));
                wd = int'($urandom_range(0, 255));
                if (wa == 3 && $urandom_range(0, 3) != 0) wd = wd & 'hF8;
                if (wa == 2 && $urandom_range(0, 1) != 0) wd = wd & 'h07;
                wr(wa, wd);
            end else begin
                idle(1);
            end
        end

        idle(2);
        @(negedge clk);
        #1;
        check("scoreboard_drained", popped, pushed);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
